// File: rtl/reg_bank_if.sv
// Command/data bundle for reg_bank: per-register commands in,
// read port, flattened contents and status flags out.
interface reg_bank_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int SELW  = 3
);
    logic [NREGS-1:0]       load;
    logic [NREGS-1:0]       inc;
    logic [NREGS-1:0]       clr;
    logic [WIDTH-1:0]       indata;
    logic                   err_clr;
    logic [SELW-1:0]        rd_sel;
    logic [WIDTH-1:0]       rd_data;
    logic [NREGS*WIDTH-1:0] outdata;
    logic [NREGS-1:0]       zero;
    logic [NREGS-1:0]       wrap;
    logic [NREGS-1:0]       err;

    modport master (
        output load, inc, clr, indata, err_clr, rd_sel,
        input  rd_data, outdata, zero, wrap, err
    );

    modport slave (
        input  load, inc, clr, indata, err_clr, rd_sel,
        output rd_data, outdata, zero, wrap, err
    );
endinterface

// File: rtl/reg_bank.sv
// Bank of NREGS load/inc/clr registers with zero/wrap/sticky-error flags.
// Build option REG_BANK_PRIORITY_EN: resolve conflicts clr > load > inc.
module reg_bank #(
    parameter int               WIDTH = 16,
    parameter int               NREGS = 8,
    parameter int               SELW  = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input logic       clk,
    input logic       rst,
    reg_bank_if.slave bus
);

    logic [WIDTH-1:0] regs_q [NREGS] = '{default: INIT};
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] wrap_q = '0;
    logic [NREGS-1:0] wrap_d;
    logic [NREGS-1:0] err_q = '0;
    logic [NREGS-1:0] err_d;
    logic [NREGS-1:0] conflict;

    always_comb begin
        regs_d   = regs_q;
        wrap_d   = '0;
        conflict = (bus.load & bus.inc) | (bus.load & bus.clr) | (bus.inc & bus.clr);
        for (int i = 0; i < NREGS; i++) begin
`ifdef REG_BANK_PRIORITY_EN
            if (bus.clr[i]) begin
                regs_d[i] = '0;
            end else if (bus.load[i]) begin
                regs_d[i] = bus.indata;
            end else if (bus.inc[i]) begin
                regs_d[i] = regs_q[i] + WIDTH'(1);
                wrap_d[i] = &regs_q[i];
            end
`else
            // A conflicting register holds; only its err bit reacts
            if (!conflict[i]) begin
                if (bus.clr[i]) begin
                    regs_d[i] = '0;
                end else if (bus.load[i]) begin
                    regs_d[i] = bus.indata;
                end else if (bus.inc[i]) begin
                    regs_d[i] = regs_q[i] + WIDTH'(1);
                    wrap_d[i] = &regs_q[i];
                end
            end
`endif
        end
        err_d = bus.err_clr ? conflict : (err_q | conflict);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= INIT;
            end
            wrap_q <= '0;
            err_q  <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.outdata = '0;
        bus.zero    = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rd_sel == SELW'(i)) begin
                bus.rd_data = regs_q[i];
            end
            bus.outdata[i*WIDTH +: WIDTH] = regs_q[i];
            bus.zero[i] = (regs_q[i] == '0);
        end
    end

    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed vector bench for reg_bank (WIDTH=16, NREGS=8, SELW=4).
// Expectations follow the build option REG_BANK_PRIORITY_EN.
module tb_reg_bank;

`ifdef REG_BANK_PRIORITY_EN
    localparam bit P = 1'b1;
`else
    localparam bit P = 1'b0;
`endif
    localparam logic [7:0] Z1 = P ? 8'h02 : 8'h00;

    typedef struct {
        logic        rst;
        logic [7:0]  ld;
        logic [7:0]  ic;
        logic [7:0]  cl;
        logic [15:0] dat;
        logic        ec;
        logic [3:0]  sel;
        logic [15:0] xd;
        logic [7:0]  xz;
        logic [7:0]  xw;
        logic [7:0]  xe;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t v [19];

    reg_bank_if #(.WIDTH(16), .NREGS(8), .SELW(4)) bus ();

    reg_bank #(
        .WIDTH(16), .NREGS(8), .SELW(4), .INIT(16'h0000)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic idle();
        bus.load    = '0;
        bus.inc     = '0;
        bus.clr     = '0;
        bus.indata  = '0;
        bus.err_clr = 1'b0;
        rst         = 1'b0;
    endtask

    initial begin
        idle();
        bus.rd_sel = '0;
        #1;
        chk("pwrup_zero", 32'(bus.zero), 32'h00FF);
        chk("pwrup_err", 32'(bus.err), 32'h0);

        v[0]  = '{1, 8'hFF, 8'h00, 8'h00, 16'hBEEF, 0, 4'd0, 16'h0000, 8'hFF, 8'h00, 8'h00};
        v[1]  = '{0, 8'h04, 8'h20, 8'h01, 16'h1234, 0, 4'd2, 16'h1234, 8'hDB, 8'h00, 8'h00};
        v[2]  = '{0, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'd5, 16'h0001, 8'hDB, 8'h00, 8'h00};
        v[3]  = '{0, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'd9, 16'h0000, 8'hDB, 8'h00, 8'h00};
        v[4]  = '{0, 8'h08, 8'h00, 8'h00, 16'hFFFF, 0, 4'd3, 16'hFFFF, 8'hD3, 8'h00, 8'h00};
        v[5]  = '{0, 8'h00, 8'h08, 8'h00, 16'h0000, 0, 4'd3, 16'h0000, 8'hDB, 8'h08, 8'h00};
        v[6]  = '{0, 8'h00, 8'h08, 8'h00, 16'h0000, 0, 4'd3, 16'h0001, 8'hD3, 8'h00, 8'h00};
        v[7]  = '{0, 8'h02, 8'h00, 8'h00, 16'h00AA, 0, 4'd1, 16'h00AA, 8'hD1, 8'h00, 8'h00};
        v[8]  = '{0, 8'h02, 8'h02, 8'h00, 16'h5555, 0, 4'd1,
                  P ? 16'h5555 : 16'h00AA, 8'hD1, 8'h00, 8'h02};
        v[9]  = '{0, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 4'd1,
                  P ? 16'h5555 : 16'h00AA, 8'hD1, 8'h00, 8'h02};
        v[10] = '{0, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 4'd1,
                  P ? 16'h5555 : 16'h00AA, 8'hD1, 8'h00, 8'h00};
        v[11] = '{0, 8'h02, 8'h00, 8'h02, 16'h1234, 1, 4'd1,
                  P ? 16'h0000 : 16'h00AA, 8'hD1 | Z1, 8'h00, 8'h02};
        v[12] = '{0, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 4'd1,
                  P ? 16'h0000 : 16'h00AA, 8'hD1 | Z1, 8'h00, 8'h00};
        v[13] = '{0, 8'h01, 8'h00, 8'h08, 16'h0000, 0, 4'd3, 16'h0000, 8'hD9 | Z1, 8'h00, 8'h00};
        v[14] = '{0, 8'h80, 8'h00, 8'h00, 16'hFFFF, 0, 4'd7, 16'hFFFF, 8'h59 | Z1, 8'h00, 8'h00};
        v[15] = '{0, 8'h00, 8'h00, 8'h80, 16'h0000, 0, 4'd7, 16'h0000, 8'hD9 | Z1, 8'h00, 8'h00};
        v[16] = '{0, 8'h10, 8'h00, 8'h00, 16'h0010, 0, 4'd4, 16'h0010, 8'hC9 | Z1, 8'h00, 8'h00};
        v[17] = '{0, 8'h10, 8'h10, 8'h10, 16'h9999, 0, 4'd4,
                  P ? 16'h0000 : 16'h0010, (P ? 8'hD9 : 8'hC9) | Z1, 8'h00, 8'h10};
        v[18] = '{0, 8'h10, 8'h10, 8'h00, 16'h7777, 0, 4'd4,
                  P ? 16'h7777 : 16'h0010, 8'hC9 | Z1, 8'h00, 8'h10};

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            rst         = v[k].rst;
            bus.load    = v[k].ld;
            bus.inc     = v[k].ic;
            bus.clr     = v[k].cl;
            bus.indata  = v[k].dat;
            bus.err_clr = v[k].ec;
            @(posedge clk);
            #1;
            idle();
            bus.rd_sel = v[k].sel;
            #1;
            chk($sformatf("v%0d_rd", k), 32'(bus.rd_data), 32'(v[k].xd));
            if (v[k].sel < 4'd8)
                chk($sformatf("v%0d_out", k),
                    32'(bus.outdata[int'(v[k].sel)*16 +: 16]), 32'(v[k].xd));
            chk($sformatf("v%0d_zero", k), 32'(bus.zero), 32'(v[k].xz));
            chk($sformatf("v%0d_wrap", k), 32'(bus.wrap), 32'(v[k].xw));
            chk($sformatf("v%0d_err", k), 32'(bus.err), 32'(v[k].xe));
        end

        // inc[6] held for five edges, reset lands on the third
        begin
            logic [15:0] exp6 [5];
            exp6 = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2};
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                bus.inc = 8'h40;
                rst     = (c == 2);
                @(posedge clk);
                #1;
                idle();
                #1;
                chk($sformatf("rstmid_c%0d_reg6", c),
                    32'(bus.outdata[6*16 +: 16]), 32'(exp6[c]));
                chk($sformatf("rstmid_c%0d_wrap", c), 32'(bus.wrap), 32'h0);
                if (c == 2) begin
                    chk("rstmid_all", 32'(bus.outdata != '0), 32'h0);
                    chk("rstmid_err", 32'(bus.err), 32'h0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised successor to the single load/inc/clr datapath register of the basic computer.
- Holds NREGS independent registers of WIDTH bits each. All registers load from one shared common-bus input.
- Each register has its own load/inc/clr command lines, plus per-register zero, wrap and sticky conflict-error flags.
- Provides a flattened parallel output and one selectable read port feeding the common-bus mux.

Parameters:
- WIDTH, 16, bits per register (>=2).
- NREGS, 8, number of registers (>=1).
- SELW, 3, width of rd_sel; must satisfy 2**SELW >= NREGS.
- INIT, 0, reset and power-up value of every register (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- load  input  NREGS  bit i: load register i from indata.
- inc  input  NREGS  bit i: increment register i by 1.
- clr  input  NREGS  bit i: clear register i to 0.
- indata  input  WIDTH  shared common-bus data.
- err_clr  input  1  clears all err bits.
- rd_sel  input  SELW  read-port register index.
- rd_data  output  WIDTH  register rd_sel (combinational).
- outdata  output  NREGS*WIDTH  register i on bits [i*WIDTH +: WIDTH].
- zero  output  NREGS  bit i = (register i == 0), combinational.
- wrap  output  NREGS  registered one-cycle pulse: inc rolled register i from all-ones to 0.
- err  output  NREGS  sticky: register i received more than one command in a cycle.

Behaviour:
- Reset (rst=1 at a rising edge): every register <= INIT; wrap <= 0; err <= 0. All commands that cycle are ignored.
- Power-up: registers initialised to INIT, wrap and err to 0. This also holds for simulation without reset.
- Per register i, each edge with rst=0, exactly one of load[i]/inc[i]/clr[i] set:
  - load: reg <= indata.
  - inc: reg <= reg+1, modulo 2**WIDTH.
  - clr: reg <= 0.
- No command set: register holds.
- Two or more commands set (default build): register holds, err[i] <= 1.
- Registers are fully independent; any mix of commands across different registers in one cycle is legal.
- wrap[i] <= 1 for exactly one cycle after an edge where the register was all-ones and inc was the sole command; otherwise wrap[i] <= 0.
  - A load or clr of 0 never sets wrap.
- err_clr=1 clears all err bits.
  - A new conflict on register i in the same cycle wins: err[i] ends at 1.
  - err holds otherwise.
- Latency:
  - Written value visible on outdata/rd_data/zero on the cycle after the edge.
  - No bypass of indata to rd_data.
- rd_sel >= NREGS: rd_data = 0.
- zero and rd_data are purely combinational from register state. Commands have no combinational path to any output.

Optional Feature:
- Macro REG_BANK_PRIORITY_EN.
- Defined: conflicting commands are resolved by fixed priority clr > load > inc.
  - The winning operation executes.
  - err[i] is still set.
  - wrap follows the executed operation only.
- Undefined: conflicting commands leave the register unchanged and set err[i] (default behaviour above).

Test Plan:
- Reset: INIT=16'h0000, drive rst=1 one edge with load=8'hFF, indata=16'hBEEF -> all outdata 0, zero=8'hFF, err=0, wrap=0.
- Load/inc/clr across registers in one cycle: load[2]=1 indata=16'h1234, inc[5]=1, clr[0]=1 -> next cycle reg2=16'h1234, reg5=16'h0001, reg0=0; rd_sel=2 gives 16'h1234; rd_sel=9 (SELW=4 build) gives 0.
- Wrap: load reg3 with 16'hFFFF, then inc[3] -> reg3=16'h0000, wrap[3]=1 for exactly one cycle, zero[3]=1; second inc gives 16'h0001 with wrap[3]=0.
- Conflict, default build:
  - reg1=16'h00AA, assert load[1]+inc[1] with indata=16'h5555 -> reg1 stays 16'h00AA, err[1]=1 and persists.
  - err_clr alone clears it.
  - err_clr plus a new conflict on reg1 in the same cycle leaves err[1]=1.
- Conflict, REG_BANK_PRIORITY_EN build: reg4=16'h0010, assert clr[4]+load[4]+inc[4] -> reg4=0, err[4]=1; load[4]+inc[4] with indata=16'h7777 -> reg4=16'h7777.
- Reset mid-operation: inc[6] held high for 5 cycles, rst=1 on cycle 3 -> reg6=INIT after that edge, counting resumes from INIT, no wrap pulse.
